// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN calculator front end.
// Instruction encoding, calculator op codes and the default stack capacity
// are shared between the instruction feeder and the calculator bench.
package rpn_pkg;

    // Instruction kind field, bits [17:16] of an encoded instruction
    typedef enum logic [1:0] {
        KIND_PUSH = 2'b00,
        KIND_NEG  = 2'b01,
        KIND_ADD  = 2'b10,
        KIND_MUL  = 2'b11
    } kind_e;

    // Calculator op codes presented on the issue port
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_NEG  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    // Encoded instruction as carried through the FIFO
    typedef struct packed {
        kind_e       kind;
        logic [15:0] data;
    } instr_t;

    localparam int INSTR_W           = $bits(instr_t);
    localparam int STACK_MAX_DEFAULT = 1000;

    // Map an instruction kind onto the calculator op it requests
    function automatic logic [1:0] kind_to_op(input kind_e k);
        logic [1:0] op;
        case (k)
            KIND_NEG: op = OP_NEG;
            KIND_ADD: op = OP_ADD;
            KIND_MUL: op = OP_MUL;
            default:  op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rpn_fifo.sv
// rpn_fifo: synchronous instruction FIFO.
// Pointers carry an extra wrap bit so occupancy is a plain subtraction and
// full/empty never alias. Storage is not reset; only the pointers are.
module rpn_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    i_wr,
    input  logic [WIDTH-1:0]        i_wdata,
    input  logic                    i_rd,
    output logic [WIDTH-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    // Occupancy and flags derive from registered pointers only, so a pop
    // on a full FIFO frees the slot for writers one cycle later.
    assign o_level = r_wptr - r_rptr;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);

    // Requests are qualified here so callers cannot overrun or underrun
    assign w_wr = i_wr && !o_full;
    assign w_rd = i_rd && !o_empty;

    // Head entry is always presented; it is valid whenever !o_empty
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Advance read/write pointers on qualified requests
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Write accepted data into storage
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/rpn_instr_feeder.sv
// rpn_instr_feeder: buffers encoded RPN instructions and issues one per
// calculator step as a registered push/d/op bundle with a one-cycle strobe,
// holding off while stall is high and forcing GAP_CYCLES idle cycles after
// each issue slot.
// Optional build macro RPN_SHADOW_CHECK_EN: track the calculator stack depth
// and drop (pop without strobe, set sticky err) instructions that would
// overflow or underflow it. Without it, shadow_cnt and err are tied to 0.
module rpn_instr_feeder
    import rpn_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int STACK_MAX  = STACK_MAX_DEFAULT
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [17:0]             in_instr,
    input  logic                    stall,
    output logic                    iss_stb,
    output logic                    iss_push,
    output logic [15:0]             iss_d,
    output logic [1:0]              iss_op,
    output logic [$clog2(DEPTH):0]  level,
    output logic [9:0]              shadow_cnt,
    output logic                    err,
    output logic                    idle
);

    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e           r_state;
    logic [3:0]       r_gap_cnt;
    logic             r_stb;
    logic             r_push;
    logic [15:0]      r_d;
    logic [1:0]       r_op;

    logic [INSTR_W-1:0] w_rdata;
    logic [LW-1:0]      w_level;
    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_pop;
    logic               w_ok;
    instr_t             w_head;

    rpn_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_wr    (w_wr),
        .i_wdata (in_instr),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head = instr_t'(w_rdata);
    assign w_wr   = in_valid && !w_full;

    // An issue slot is taken whenever the FSM may issue, an entry is
    // waiting and downstream is ready. IDLE issues directly so the first
    // strobe follows acceptance into an empty FIFO by a single cycle.
    assign w_pop = ((r_state == ST_IDLE) || (r_state == ST_ISSUE))
                   && !w_empty && !stall;

`ifdef RPN_SHADOW_CHECK_EN
    logic [9:0] r_shadow_cnt;
    logic       r_err;
    logic [9:0] w_cnt_nxt;

    // Decide whether the head instruction is legal for the tracked depth
    always_comb begin
        w_ok      = 1'b0;
        w_cnt_nxt = r_shadow_cnt;
        case (w_head.kind)
            KIND_PUSH: begin
                if (r_shadow_cnt != 10'(STACK_MAX)) begin
                    w_ok      = 1'b1;
                    w_cnt_nxt = r_shadow_cnt + 10'd1;
                end
            end
            KIND_NEG: begin
                w_ok = (r_shadow_cnt >= 10'd1);
            end
            default: begin
                if (r_shadow_cnt >= 10'd2) begin
                    w_ok      = 1'b1;
                    w_cnt_nxt = r_shadow_cnt - 10'd1;
                end
            end
        endcase
    end

    // Track calculator depth on issue; a dropped slot raises sticky err
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_shadow_cnt <= '0;
            r_err        <= 1'b0;
        end else if (w_pop) begin
            if (w_ok) begin
                r_shadow_cnt <= w_cnt_nxt;
            end else begin
                r_err <= 1'b1;
            end
        end
    end

    assign shadow_cnt = r_shadow_cnt;
    assign err        = r_err;
`else
    assign w_ok       = 1'b1;
    assign shadow_cnt = '0;
    assign err        = 1'b0;
`endif

    // Issue FSM with registered strobe and issue bundle
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_stb     <= 1'b0;
            r_push    <= 1'b0;
            r_d       <= '0;
            r_op      <= OP_NONE;
        end else begin
            r_stb  <= 1'b0;
            r_push <= 1'b0;
            r_d    <= '0;
            r_op   <= OP_NONE;
            case (r_state)
                ST_IDLE, ST_ISSUE: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                    end else if (stall) begin
                        r_state <= ST_ISSUE;
                    end else begin
                        // Slot taken: strobe only if the instruction is legal
                        if (w_ok) begin
                            r_stb  <= 1'b1;
                            r_push <= (w_head.kind == KIND_PUSH);
                            r_d    <= (w_head.kind == KIND_PUSH) ? w_head.data : '0;
                            r_op   <= kind_to_op(w_head.kind);
                        end
                        if (GAP_CYCLES > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= 4'(GAP_CYCLES - 1);
                        end else if (w_level > LW'(1)) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= w_empty ? ST_IDLE : ST_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = !w_full;
    assign level    = w_level;
    assign iss_stb  = r_stb;
    assign iss_push = r_push;
    assign iss_d    = r_d;
    assign iss_op   = r_op;
    assign idle     = (r_state == ST_IDLE) && w_empty;

endmodule

// File: tb/tb_rpn_instr_feeder.sv
// tb_rpn_instr_feeder: randomized and directed stimulus for rpn_instr_feeder
// against a queue-based reference model of the instruction stream.
module tb_rpn_instr_feeder;

    localparam int DEPTH = 8;
    localparam int GAP   = 1;
    localparam int SMAX  = 1000;

    typedef struct {
        logic        push;
        logic [15:0] d;
        logic [1:0]  op;
        int          cnt;
    } iss_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_instr = '0;
    logic        stall = 1'b0;
    logic        iss_stb;
    logic        iss_push;
    logic [15:0] iss_d;
    logic [1:0]  iss_op;
    logic [3:0]  level;
    logic [9:0]  shadow_cnt;
    logic        err;
    logic        idle;

    int n_checks = 0;
    int n_errs   = 0;

    iss_t exp_q[$];
    iss_t obs_q[$];
    int   stb_cyc_q[$];
    int   m_cnt = 0;
    bit   m_err = 0;
    int   m_issued = 0;
    int   acc_total = 0;
    int   stb_total = 0;
    int   cyc = 0;
    int   last_stb_cyc = -100;
    int   last_acc_cyc = 0;
    bit   stall_edge = 0;
    int   stall_mode = 1;

    always #5 clk = ~clk;

    rpn_instr_feeder #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .STACK_MAX  (SMAX)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .stall      (stall),
        .iss_stb    (iss_stb),
        .iss_push   (iss_push),
        .iss_d      (iss_d),
        .iss_op     (iss_op),
        .level      (level),
        .shadow_cnt (shadow_cnt),
        .err        (err),
        .idle       (idle)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: what the calculator should see for an accepted instruction
    function automatic void model_accept(input logic [17:0] ins);
        iss_t       e;
        logic [1:0] k;
        bit         ok;
        int         nc;
        k  = ins[17:16];
        ok = 1;
        nc = 0;
`ifdef RPN_SHADOW_CHECK_EN
        nc = m_cnt;
        if (k == 2'b00) begin
            if (m_cnt < SMAX) nc = m_cnt + 1; else ok = 0;
        end else if (k == 2'b01) begin
            ok = (m_cnt >= 1);
        end else begin
            if (m_cnt >= 2) nc = m_cnt - 1; else ok = 0;
        end
`endif
        acc_total++;
        last_acc_cyc = cyc;
        if (ok) begin
            m_cnt  = nc;
            e.push = (k == 2'b00);
            e.d    = (k == 2'b00) ? ins[15:0] : 16'h0;
            e.op   = k;
            e.cnt  = nc;
            exp_q.push_back(e);
            m_issued++;
        end else begin
            m_err = 1;
        end
    endfunction

    // Evaluate the observed issue stream as the calculator would
    function automatic int calc_top();
        logic [15:0] st[$];
        logic [15:0] a;
        logic [15:0] b;
        foreach (obs_q[i]) begin
            if (obs_q[i].push) begin
                st.push_back(obs_q[i].d);
            end else if (st.size() > 0) begin
                a = st.pop_back();
                if (obs_q[i].op == 2'd1) begin
                    st.push_back(16'h0 - a);
                end else if (st.size() > 0) begin
                    b = st.pop_back();
                    st.push_back((obs_q[i].op == 2'd2) ? (a + b) : (a * b));
                end
            end
        end
        return (st.size() > 0) ? int'(st[st.size()-1]) : -1;
    endfunction

    function automatic logic [17:0] rand_instr();
        logic [1:0] k;
        k = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
        return {k, 16'($urandom)};
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        stall_edge <= stall;
    end

    // Stall generator: 0 low, 1 high, 2 toggle every cycle, 3 random
    always begin
        @(posedge clk);
        #1;
        case (stall_mode)
            0:       stall = 1'b0;
            1:       stall = 1'b1;
            2:       stall = ~stall;
            default: stall = ($urandom_range(0, 3) == 0);
        endcase
    end

    // Monitor: compare every cycle's issue port against the model
    always @(negedge clk) begin : mon
        iss_t e;
        if (!nrst) begin
            if (iss_stb) begin
                stb_total++;
                check("stall_at_strobe", 32'(stall_edge), 32'd0);
                check("strobe_gap", 32'((cyc - last_stb_cyc) > GAP), 32'd1);
                last_stb_cyc = cyc;
                stb_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("iss_push", 32'(iss_push), 32'(e.push));
                    check("iss_d", 32'(iss_d), 32'(e.d));
                    check("iss_op", 32'(iss_op), 32'(e.op));
                    check("shadow_cnt", 32'(shadow_cnt), 32'(e.cnt));
                end
                e.push = iss_push;
                e.d    = iss_d;
                e.op   = iss_op;
                e.cnt  = 0;
                obs_q.push_back(e);
            end else begin
                check("quiet_outputs", 32'({iss_push, iss_d, iss_op}), 32'd0);
            end
`ifndef RPN_SHADOW_CHECK_EN
            check("level", 32'(level), 32'(acc_total - stb_total));
`endif
        end
    end

    task automatic send(input logic [17:0] ins);
        int waited;
        bit acc;
        waited   = 0;
        acc      = 0;
        in_valid = 1'b1;
        in_instr = ins;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_accept(ins);
            end else begin
                waited++;
                if (waited > 300) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && idle === 1'b1)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                check("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        repeat (GAP + 2) @(posedge clk);
        #1;
        check("drained_level", 32'(level), 32'd0);
        check("err_state", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_cnt        = 0;
        m_err        = 0;
        acc_total    = 0;
        stb_total    = 0;
        last_stb_cyc = -100;
        nrst         = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_stb", 32'(iss_stb), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_shadow", 32'(shadow_cnt), 32'd0);
    endtask

    initial begin
        int base;
        int iss0;
        stall_mode = 1;
        do_reset();

        // Reset with three entries buffered
        send({2'b00, 16'd11});
        send({2'b00, 16'd22});
        send({2'b00, 16'd33});
        check("prefill_level", 32'(level), 32'd3);
        do_reset();

        // Stream PUSH 5, PUSH 7, ADD
        stall_mode = 0;
        @(posedge clk);
        #1;
        obs_q.delete();
        stb_cyc_q.delete();
        send({2'b00, 16'd5});
        base = last_acc_cyc;
        send({2'b00, 16'd7});
        send({2'b10, 16'h1234});
        drain();
        check("stream_count", 32'(stb_cyc_q.size()), 32'd3);
        if (stb_cyc_q.size() == 3) begin
            check("first_latency", 32'(stb_cyc_q[0] - base), 32'd1);
            check("spacing_1", 32'(stb_cyc_q[1] - stb_cyc_q[0]), 32'(GAP + 1));
            check("spacing_2", 32'(stb_cyc_q[2] - stb_cyc_q[1]), 32'(GAP + 1));
        end
        check("calc_result", 32'(calc_top()), 32'd12);

        // Fill the FIFO while stalled, then release
        do_reset();
        stall_mode = 1;
        iss0 = m_issued;
        for (int i = 0; i < DEPTH; i++) send({2'b00, 16'(100 + i)});
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'(DEPTH));
        in_valid = 1'b1;
        in_instr = {2'b00, 16'd200};
        repeat (3) begin
            @(posedge clk);
            #1;
            check("held_level", 32'(level), 32'(DEPTH));
        end
        stall_mode = 0;
        send({2'b00, 16'd200});
        drain();
        check("fill_issued", 32'(m_issued - iss0), 32'(DEPTH + 1));

        // Stall toggling every cycle while issuing
        do_reset();
        stall_mode = 2;
        for (int i = 0; i < 6; i++) send({2'b00, 16'($urandom)});
        drain();
        stall_mode = 0;

        // Illegal-depth sequence: NEG on empty stack, then PUSH 3, PUSH FFFF, MUL
        do_reset();
        obs_q.delete();
        send({2'b01, 16'd0});
        send({2'b00, 16'd3});
        send({2'b00, 16'hFFFF});
        send({2'b11, 16'd0});
        drain();
`ifdef RPN_SHADOW_CHECK_EN
        check("neg_dropped_err", 32'(err), 32'd1);
        check("neg_shadow_end", 32'(shadow_cnt), 32'd1);
        check("neg_first_issue", 32'(obs_q.size() > 0 ? obs_q[0].d : 16'hDEAD), 32'd3);
`else
        check("neg_err", 32'(err), 32'd0);
        check("neg_first_op", 32'(obs_q.size() > 0 ? obs_q[0].op : 2'd0), 32'd1);
        check("mul_op", 32'(obs_q.size() > 3 ? obs_q[3].op : 2'd0), 32'd3);
`endif

        // Randomized traffic with random stall
        do_reset();
        stall_mode = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(rand_instr());
            end
        end
        stall_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
